piso_serializer: RTL and testbench

Parallel-in serial-out transmitter. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit per clock. Words stream back-to-back with no idle cycle between them. It sits directly upstream of the `sipo` deserializer: `outbit` drives the `sipo` serial input and `out_last` marks the clock on which `sipo` holds a complete word.

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_serializer.sv | 116 +++++++++++
 tb/tb_piso_serializer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
package piso_pkg;

   // IDLE: shifter empty. SHIFT: a word is on the serial line.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } piso_state_t;

   // Width of the bit counter that walks one word.
   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with a one-word hold buffer so that
// consecutive words leave back-to-back with no idle bit between them.
//
// Handshake: a word transfers on any rising edge where in_valid && in_ready.
// in_ready depends only on registered state (the hold buffer being empty),
// never on in_valid, and in_data is ignored while in_ready is low.
//
// WIDTH must be at least 2 and match the downstream deserializer width.
module piso_serializer
   import piso_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             outbit,
   output logic             out_valid,
   output logic             out_last,
   output logic             busy
);

   localparam int            CW       = cnt_w(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   piso_state_t      state;
   logic [WIDTH-1:0] sreg;
   logic [WIDTH-1:0] hold;
   logic [CW-1:0]    cnt;
   logic             hold_full;

   logic [WIDTH-1:0] sreg_shifted;
   logic             head_bit;
   logic             xfer;
   logic             on_last;

   // Next shift-register value and the bit currently presented on the line.
   always_comb begin
      sreg_shifted = '0;
      head_bit     = 1'b0;
      if (MSB_FIRST) begin
         sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
         head_bit     = sreg[WIDTH-1];
      end else begin
         sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
         head_bit     = sreg[0];
      end
   end

   assign in_ready  = !hold_full;
   assign xfer      = in_valid && in_ready;
   assign on_last   = (state == SHIFT) && (cnt == CNT_LAST);

   assign out_valid = (state == SHIFT);
   assign out_last  = on_last;
   assign busy      = out_valid || hold_full;
   // Line is held low whenever no data bit is being sent.
   assign outbit    = out_valid && head_bit;

   // Transmit FSM: routes accepted words to the shifter or the hold buffer
   // and reloads the shifter from hold at each word boundary.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         sreg      <= '0;
         hold      <= '0;
         cnt       <= '0;
         hold_full <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (xfer) begin
                  sreg  <= in_data;
                  cnt   <= '0;
                  state <= SHIFT;
               end
            end

            SHIFT: begin
               if (on_last) begin
                  if (hold_full) begin
                     // Held word follows immediately. in_ready is low this
                     // cycle, so no new word can arrive on the same edge.
                     sreg      <= hold;
                     cnt       <= '0;
                     hold_full <= 1'b0;
                  end else if (xfer) begin
                     // Fresh word goes straight to the shifter: no gap.
                     sreg <= in_data;
                     cnt  <= '0;
                  end else begin
                     sreg  <= sreg_shifted;
                     cnt   <= '0;
                     state <= IDLE;
                  end
               end else begin
                  sreg <= sreg_shifted;
                  cnt  <= cnt + CW'(1);
                  if (xfer) begin
                     hold      <= in_data;
                     hold_full <= 1'b1;
                  end
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: a transaction model predicts the line, a bit
// queue holds the expected serial stream, and a word queue feeds a small
// behavioural deserializer loopback compared on each out_last cycle.
module tb_piso_serializer;

   localparam int W = 4;

   logic         clk;
   logic         rst;

   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_ready;
   logic         outbit;
   logic         out_valid;
   logic         out_last;
   logic         busy;

   logic [W-1:0] in_data_l;
   logic         in_valid_l;
   logic         in_ready_l;
   logic         outbit_l;
   logic         out_valid_l;
   logic         out_last_l;
   logic         busy_l;

   int           n_checks;
   int           n_errors;

   // Scoreboard state
   logic         bit_q[$];
   logic [W-1:0] exp_q[$];
   int           m_rem;
   logic         m_hold;
   logic [W-1:0] sipo_sr;

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
      .in_ready(in_ready), .outbit(outbit), .out_valid(out_valid),
      .out_last(out_last), .busy(busy)
   );

   piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
      .clk(clk), .rst(rst), .in_data(in_data_l), .in_valid(in_valid_l),
      .in_ready(in_ready_l), .outbit(outbit_l), .out_valid(out_valid_l),
      .out_last(out_last_l), .busy(busy_l)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: update the model at the edge, then check every output.
   task automatic step();
      logic         xfer;
      logic         rst_s;
      logic         was_last;
      logic [W-1:0] sipo_next;
      logic         exp_bit;
      logic [W-1:0] exp_w;
      rst_s     = rst;
      xfer      = in_valid && !m_hold && !rst;
      was_last  = out_last;
      sipo_next = out_valid ? {sipo_sr[W-2:0], outbit} : sipo_sr;
      @(posedge clk);
      if (rst_s) begin
         m_rem    = 0;
         m_hold   = 1'b0;
         bit_q.delete();
         exp_q.delete();
         sipo_sr  = '0;
         was_last = 1'b0;
      end else begin
         if (m_rem == 1) begin
            if (m_hold) begin
               m_rem  = W;
               m_hold = 1'b0;
            end else if (xfer) begin
               m_rem = W;
            end else begin
               m_rem = 0;
            end
         end else if (m_rem > 1) begin
            m_rem = m_rem - 1;
            if (xfer) m_hold = 1'b1;
         end else if (xfer) begin
            m_rem = W;
         end
         if (xfer) begin
            for (int i = W - 1; i >= 0; i--) bit_q.push_back(in_data[i]);
            exp_q.push_back(in_data);
         end
         sipo_sr = sipo_next;
      end
      #1;
      chk("in_ready", in_ready, !m_hold);
      chk("out_valid", out_valid, m_rem != 0);
      chk("out_last", out_last, m_rem == 1);
      chk("busy", busy, (m_rem != 0) || m_hold);
      exp_bit = 1'b0;
      if (m_rem != 0 && bit_q.size() != 0) exp_bit = bit_q.pop_front();
      chk("outbit", outbit, exp_bit);
      if (was_last) begin
         exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
         chk("loopback_word", sipo_sr, exp_w);
      end
   endtask

   // Present a word and hold it until the model says it was taken.
   task automatic send(input logic [W-1:0] w);
      logic took;
      int   guard;
      guard    = 0;
      took     = 1'b0;
      in_data  = w;
      in_valid = 1'b1;
      while (!took && guard < 50) begin
         took = !m_hold;
         step();
         guard++;
      end
      if (!took) begin
         n_checks++;
         n_errors++;
         $error("FAIL send_timeout: word %0h not taken, expected accept within 50 cycles", w);
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      m_rem      = 0;
      m_hold     = 1'b0;
      sipo_sr    = '0;
      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      in_valid_l = 1'b0;
      in_data_l  = '0;

      // Reset state
      step();
      step();
      rst = 1'b0;
      step();
      chk("reset_lsb_in_ready", in_ready_l, 1'b1);
      chk("reset_lsb_out_valid", out_valid_l, 1'b0);
      chk("reset_lsb_busy", busy_l, 1'b0);

      // Single word 1011, then line goes idle
      send(4'b1011);
      idle(5);

      // Back-to-back: A then 5 with in_valid held high
      send(4'hA);
      send(4'h5);
      idle(10);

      // Backpressure: third word waits for the hold buffer to drain
      send(4'h1);
      send(4'h2);
      send(4'h3);
      idle(14);

      // Reset mid-word, with a word offered on the reset edge
      send(4'hF);
      in_valid = 1'b0;
      step();
      rst      = 1'b1;
      in_data  = 4'h9;
      in_valid = 1'b1;
      step();
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("rst_mid_outbit", outbit, 1'b0);
      chk("rst_mid_in_ready", in_ready, 1'b1);
      step();
      send(4'h6);
      idle(6);

      // LSB-first instance: 1000 leaves as 0,0,0,1
      chk("lsb_ready_before", in_ready_l, 1'b1);
      in_data_l  = 4'b1000;
      in_valid_l = 1'b1;
      step();
      in_valid_l = 1'b0;
      chk("lsb_valid0", out_valid_l, 1'b1);
      chk("lsb_bit0", outbit_l, 1'b0);
      step();
      chk("lsb_bit1", outbit_l, 1'b0);
      step();
      chk("lsb_bit2", outbit_l, 1'b0);
      chk("lsb_last_early", out_last_l, 1'b0);
      step();
      chk("lsb_bit3", outbit_l, 1'b1);
      chk("lsb_last", out_last_l, 1'b1);
      step();
      chk("lsb_valid_after", out_valid_l, 1'b0);
      chk("lsb_busy_after", busy_l, 1'b0);
      chk("lsb_outbit_after", outbit_l, 1'b0);

      // Loopback: 16 random words with random idle gaps
      for (int k = 0; k < 16; k++) begin
         send(W'($urandom_range(0, (1 << W) - 1)));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      idle(14);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
